// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : connect4_pkg
//  Purpose  : Shared definitions for the Connect-4 piece plotter: the draw-mode
//             encodings, the plotter FSM state encoding and the default
//             colours.
//  Revision : 1.0  initial release
// ============================================================================
package connect4_pkg;

    // Draw command modes
    localparam logic [1:0] C_MODE_PLACE = 2'b00;
    localparam logic [1:0] C_MODE_HOVER = 2'b01;
    localparam logic [1:0] C_MODE_DROP  = 2'b10;
    localparam logic [1:0] C_MODE_ERASE = 2'b11;

    // Plotter FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAW   = 3'd1,
        S_WAIT   = 3'd2,
        S_ERASE  = 3'd3,
        S_DONE   = 3'd4,
        S_REJECT = 3'd5
    } state_t;

    // Default colours
    localparam logic [2:0] C_COL_P0 = 3'b100;
    localparam logic [2:0] C_COL_P1 = 3'b110;
    localparam logic [2:0] C_COL_BG = 3'b000;

endpackage
`default_nettype wire

// File: rtl/square_raster.sv
`default_nettype none
// ============================================================================
//  Module   : square_raster
//  Purpose  : Pixel counter that walks a BLOCK x BLOCK square in raster order
//             (dx fastest). Shared by the draw and erase passes.
//  Ports    : clk, reset     clock, async active-high reset
//             load           restart at pixel 0 (priority over step)
//             step           advance one pixel
//             dx, dy         current offset inside the square
//             last           current pixel is the final one of the square
//  Revision : 1.0  initial release
// ============================================================================
module square_raster #(
    parameter int BLOCK = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       step,
    output logic [$clog2(BLOCK)-1:0]   dx,
    output logic [$clog2(BLOCK)-1:0]   dy,
    output logic                       last
);

    localparam int               LB    = $clog2(BLOCK);
    localparam logic [2*LB-1:0]  C_ONE = 1;

    logic [2*LB-1:0] r_cnt;

    // BLOCK is a power of two, so the counter wraps to 0 by itself after the
    // last pixel; a following pass can start without an explicit load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (step) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    assign dx   = r_cnt[LB-1:0];
    assign dy   = r_cnt[2*LB-1:LB];
    assign last = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/piece_plotter.sv
`default_nettype none
// ============================================================================
//  Module   : piece_plotter
//  Purpose  : Rasterises one Connect-4 piece (BLOCK x BLOCK square) into the
//             VGA adapter, one pixel per clock. Modes: place, hover, animated
//             drop (draw / wait / erase row by row) and erase.
//  Ports    : clk, reset              clock, async active-high reset
//             start                   command strobe (taken only when idle)
//             col, row, player, mode  command fields
//             x, y, colour, plot      registered pixel write to the adapter
//             busy                    command in progress
//             done                    one-cycle completion pulse
//             err                     one-cycle pulse with done on rejection
//  Revision : 1.0  initial release
// ============================================================================
module piece_plotter
    import connect4_pkg::*;
#(
    parameter int         GRID      = 2,
    parameter int         BLOCK     = 4,
    parameter int         COLS      = 7,
    parameter int         ROWS      = 6,
    parameter int         X_W       = 9,
    parameter int         Y_W       = 9,
    parameter int         HOVER_Y   = 128,
    parameter int         FRAME_DLY = 3000000,
    parameter logic [2:0] COL_P0    = C_COL_P0,
    parameter logic [2:0] COL_P1    = C_COL_P1,
    parameter logic [2:0] COL_BG    = C_COL_BG
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2:0]     col,
    input  logic [2:0]     row,
    input  logic           player,
    input  logic [1:0]     mode,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int LB     = $clog2(BLOCK);
    localparam int WAIT_W = $clog2(FRAME_DLY + 1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [2:0]        r_col;
    logic [2:0]        r_row;
    logic [2:0]        r_cur_row;
    logic              r_player;
    logic [1:0]        r_mode;
    logic [WAIT_W-1:0] r_wait;

    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [2:0]        r_colour;
    logic              r_plot;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_bad_cmd;
    logic              w_accept;
    logic              w_rast_load;
    logic              w_rast_step;
    logic              w_row_inc;
    logic              w_pix_plot;
    logic              w_pix_bg;
    logic              w_busy;
    logic              w_done;
    logic              w_err;
    logic [LB-1:0]     w_dx;
    logic [LB-1:0]     w_dy;
    logic              w_last;
    logic [X_W-1:0]    w_bx;
    logic [Y_W-1:0]    w_by;

    square_raster #(
        .BLOCK (BLOCK)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .load  (w_rast_load),
        .step  (w_rast_step),
        .dx    (w_dx),
        .dy    (w_dy),
        .last  (w_last)
    );

    // Hover ignores the row field, so only its column is range-checked.
    assign w_bad_cmd = (int'(col) >= COLS) ||
                       ((mode != C_MODE_HOVER) && (int'(row) >= ROWS));

    // Cell origin: (n+1)*GRID + n*BLOCK == n*(GRID+BLOCK) + GRID
    assign w_bx = X_W'(r_col) * X_W'(GRID + BLOCK) + X_W'(GRID);
    assign w_by = (r_mode == C_MODE_HOVER) ? Y_W'(HOVER_Y)
                : Y_W'(r_cur_row) * Y_W'(GRID + BLOCK) + Y_W'(GRID);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rast_load = 1'b0;
        w_rast_step = 1'b0;
        w_row_inc   = 1'b0;
        w_pix_plot  = 1'b0;
        w_pix_bg    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_rast_load = 1'b1;
                    w_state_nxt = w_bad_cmd ? S_REJECT : S_DRAW;
                end
            end
            S_DRAW: begin
                w_busy      = 1'b1;
                w_pix_plot  = 1'b1;
                w_pix_bg    = (r_mode == C_MODE_ERASE);
                w_rast_step = 1'b1;
                if (w_last) begin
                    if ((r_mode == C_MODE_DROP) && (r_cur_row != r_row)) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (r_wait == WAIT_W'(FRAME_DLY - 1)) begin
                    w_rast_load = 1'b1;
                    w_state_nxt = S_ERASE;
                end
            end
            S_ERASE: begin
                w_busy      = 1'b1;
                w_pix_plot  = 1'b1;
                w_pix_bg    = 1'b1;
                w_rast_step = 1'b1;
                if (w_last) begin
                    w_row_inc   = 1'b1;
                    w_state_nxt = S_DRAW;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_REJECT: begin
                w_done      = 1'b1;
                w_err       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latches, frame-delay counter and registered pixel outputs.
    // Outputs are registered from the current state, which puts the first
    // plot and the rising busy on the edge after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col     <= '0;
            r_row     <= '0;
            r_cur_row <= '0;
            r_player  <= 1'b0;
            r_mode    <= '0;
            r_wait    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_plot    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col     <= col;
                r_row     <= row;
                r_player  <= player;
                r_mode    <= mode;
                r_cur_row <= (mode == C_MODE_DROP) ? 3'd0 : row;
            end else if (w_row_inc) begin
                r_cur_row <= r_cur_row + 3'd1;
            end

            r_wait <= (r_state == S_WAIT) ? r_wait + WAIT_W'(1) : '0;

            r_plot <= w_pix_plot;
            r_busy <= w_busy;
            r_done <= w_done;
            r_err  <= w_err;

            // Position and colour hold their last value while plot is low.
            if (w_pix_plot) begin
                r_x      <= w_bx + X_W'(w_dx);
                r_y      <= w_by + Y_W'(w_dy);
                r_colour <= w_pix_bg ? COL_BG : (r_player ? COL_P1 : COL_P0);
            end
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_piece_plotter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piece_plotter
//  Purpose  : Self-checking bench for piece_plotter (GRID=2, BLOCK=4,
//             FRAME_DLY=4). Expected pixel streams come from a behavioural
//             model built from the drawing rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piece_plotter;

    localparam int GRID  = 2;
    localparam int BLOCK = 4;
    localparam int FDLY  = 4;
    localparam int HOV_Y = 128;
    localparam int NCOL  = 7;
    localparam int NROW  = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] col;
    logic [2:0] row;
    logic       player;
    logic [1:0] mode;
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        logic       p;
        logic [8:0] px;
        logic [8:0] py;
        logic [2:0] c;
    } pix_t;

    pix_t       exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [8:0] lx = '0;
    logic [8:0] ly = '0;
    logic [2:0] lc = '0;

    piece_plotter #(
        .GRID      (GRID),
        .BLOCK     (BLOCK),
        .COLS      (NCOL),
        .ROWS      (NROW),
        .X_W       (9),
        .Y_W       (9),
        .HOVER_Y   (HOV_Y),
        .FRAME_DLY (FDLY),
        .COL_P0    (3'b100),
        .COL_P1    (3'b110),
        .COL_BG    (3'b000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .col    (col),
        .row    (row),
        .player (player),
        .mode   (mode),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got still running, want finished");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int cell_y(int r);
        return (r + 1) * GRID + r * BLOCK;
    endfunction

    function automatic void push_pass(int bx, int by, logic [2:0] c);
        for (int i = 0; i < BLOCK * BLOCK; i++) begin
            pix_t p;
            p.p  = 1'b1;
            p.px = 9'(bx + i % BLOCK);
            p.py = 9'(by + i / BLOCK);
            p.c  = c;
            exp_q.push_back(p);
        end
    endfunction

    function automatic void push_idle(int n);
        pix_t p;
        p   = exp_q[$];
        p.p = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(p);
    endfunction

    // Fills exp_q with the per-cycle pixel stream; returns 1 for a rejection.
    function automatic bit build(int c, int r, bit pl, int m);
        logic [2:0] pc;
        int         bx;
        exp_q.delete();
        if (c >= NCOL || (m != 1 && r >= NROW)) return 1'b1;
        pc = pl ? 3'b110 : 3'b100;
        bx = (c + 1) * GRID + c * BLOCK;
        case (m)
            0: push_pass(bx, cell_y(r), pc);
            1: push_pass(bx, HOV_Y, pc);
            3: push_pass(bx, cell_y(r), 3'b000);
            default: begin
                for (int k = 0; k <= r; k++) begin
                    push_pass(bx, cell_y(k), pc);
                    if (k < r) begin
                        push_idle(FDLY);
                        push_pass(bx, cell_y(k), 3'b000);
                    end
                end
            end
        endcase
        return 1'b0;
    endfunction

    // ---------------- command runner ----------------
    task automatic run_cmd(input string tag, input int c, input int r, input bit pl,
                           input int m, input bit noise, output int plots);
        bit rej;
        int n;
        rej   = build(c, r, pl, m);
        n     = exp_q.size();
        plots = 0;
        @(negedge clk);
        col = 3'(c); row = 3'(r); player = pl; mode = 2'(m); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (noise && i >= 2 && i < 6) begin
                start  = 1'b1;
                col    = 3'($urandom);
                row    = 3'($urandom);
                player = 1'($urandom);
                mode   = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (plot) plots++;
            n_vec++;
            if ({plot, x, y, colour, busy, done, err} !==
                {exp_q[i].p, exp_q[i].px, exp_q[i].py, exp_q[i].c, 1'b1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL %s pixel %0d: got plot=%b x=%0d y=%0d colour=%b busy=%b done=%b err=%b, want plot=%b x=%0d y=%0d colour=%b busy=1 done=0 err=0",
                         tag, i, plot, x, y, colour, busy, done, err,
                         exp_q[i].p, exp_q[i].px, exp_q[i].py, exp_q[i].c);
            end
        end
        start = 1'b0;
        if (n > 0) begin
            lx = exp_q[n-1].px; ly = exp_q[n-1].py; lc = exp_q[n-1].c;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({plot, busy, done, err, x, y, colour} !== {1'b0, 1'b0, 1'b1, rej, lx, ly, lc}) begin
            n_bad++;
            $display("FAIL %s done-cycle: got plot=%b busy=%b done=%b err=%b x=%0d y=%0d colour=%b, want plot=0 busy=0 done=1 err=%b x=%0d y=%0d colour=%b",
                     tag, plot, busy, done, err, x, y, colour, rej, lx, ly, lc);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({plot, busy, done, err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s after-done: got plot=%b busy=%b done=%b err=%b, want all 0",
                     tag, plot, busy, done, err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; col = '0; row = '0; player = 1'b0; mode = '0;
        #2;
        n_vec++;
        if ({x, y, colour, plot, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got x=%0d y=%0d colour=%b plot=%b busy=%b done=%b err=%b, want all 0",
                     x, y, colour, plot, busy, done, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_place();
        int plots;
        run_cmd("place_c0r0p0", 0, 0, 1'b0, 0, 1'b0, plots);
        n_vec++;
        if (plots !== 16) begin
            n_bad++;
            $display("FAIL place_plot_count: got %0d, want 16", plots);
        end
    endtask

    task automatic test_hover();
        int plots;
        run_cmd("hover_c6p1_row7", 6, 7, 1'b1, 1, 1'b0, plots);
    endtask

    task automatic test_drop();
        int plots;
        run_cmd("drop_c3r2p0", 3, 2, 1'b0, 2, 1'b0, plots);
        n_vec++;
        if (plots !== 80) begin
            n_bad++;
            $display("FAIL drop_plot_count: got %0d, want 80", plots);
        end
        run_cmd("drop_row0", 5, 0, 1'b1, 2, 1'b0, plots);
        run_cmd("drop_row5", 0, 5, 1'b1, 2, 1'b0, plots);
    endtask

    task automatic test_erase();
        int plots;
        run_cmd("erase_c1r5", 1, 5, 1'b1, 3, 1'b0, plots);
    endtask

    task automatic test_reject();
        int plots;
        run_cmd("reject_col7", 7, 0, 1'b0, 0, 1'b0, plots);
        n_vec++;
        if (plots !== 0) begin
            n_bad++;
            $display("FAIL reject_no_plot: got %0d plots, want 0", plots);
        end
        run_cmd("reject_row6", 2, 6, 1'b1, 3, 1'b0, plots);
        run_cmd("reject_drop_row7", 4, 7, 1'b0, 2, 1'b0, plots);
    endtask

    task automatic test_busy_ignore();
        int plots;
        run_cmd("place_with_restart", 2, 3, 1'b1, 0, 1'b1, plots);
    endtask

    task automatic test_reset_mid();
        int plots;
        @(negedge clk);
        col = 3'd3; row = 3'd2; player = 1'b0; mode = 2'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({x, y, colour, plot, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_drop: got x=%0d y=%0d colour=%b plot=%b busy=%b done=%b err=%b, want all 0",
                     x, y, colour, plot, busy, done, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({plot, busy, done, err} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_no_done cycle %0d: got plot=%b busy=%b done=%b err=%b, want all 0",
                         i, plot, busy, done, err);
            end
        end
        lx = '0; ly = '0; lc = '0;
        run_cmd("place_after_reset", 0, 0, 1'b0, 0, 1'b0, plots);
    endtask

    task automatic test_random();
        int plots;
        for (int k = 0; k < 12; k++) begin
            run_cmd("random", $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom), $urandom_range(0, 3), 1'($urandom), plots);
        end
    endtask

    initial begin
        test_reset();
        test_place();
        test_hover();
        test_drop();
        test_erase();
        test_reject();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
